// File: rtl/sar_result_averager.sv
// ----------------------------------------------------------------------------
// sar_result_averager
//
// Sits downstream of the 10-bit SAR conversion logic. It captures one
// conversion result on each rising edge of eoc, averages 2**LOG2_AVG
// consecutive results with round-half-up, and queues each average in a small
// first-word-fall-through FIFO. A consumer drains the FIFO with a valid/ready
// handshake. If an average arrives while the FIFO is full and nothing is
// popped in that cycle, the average is dropped and the sticky overrun flag is
// raised.
//
// Parameters
//   N_BITS      width of the SAR result and of each averaged output
//   LOG2_AVG    log2 of samples per average, 0..4 (0 = pass-through)
//   DEPTH_LOG2  log2 of the output FIFO depth
//
// Ports
//   clk         system clock, shared with the SAR logic
//   rst         asynchronous active-low reset
//   en          1 = accept eoc edges, 0 = ignore them (accumulator holds)
//   clr         synchronous clear of accumulator, count, FIFO and overrun
//   sar         conversion result from the SAR logic
//   eoc         end of conversion, level or pulse; only rising edges count
//   dout        FIFO head (averaged result), 0 while the FIFO is empty
//   dout_valid  FIFO is non-empty
//   dout_ready  consumer takes dout this cycle
//   fill        exact FIFO occupancy, 0..2**DEPTH_LOG2
//   overrun     sticky: an average was dropped because the FIFO was full
// ----------------------------------------------------------------------------
module sar_result_averager #(
    parameter int N_BITS     = 10,
    parameter int LOG2_AVG   = 2,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [N_BITS-1:0]     sar,
    input  logic                  eoc,
    output logic [N_BITS-1:0]     dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DEPTH_LOG2:0]   fill,
    output logic                  overrun
);

    // The accumulator carries LOG2_AVG extra bits so a full window of
    // all-ones samples plus the rounding term can never wrap.
    localparam int ACC_W  = N_BITS + LOG2_AVG;
    localparam int CNT_W  = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int DEPTH  = 2 ** DEPTH_LOG2;
    localparam int LAST_I = (2 ** LOG2_AVG) - 1;
    localparam int HALF_I = (2 ** LOG2_AVG) / 2;

    localparam logic [CNT_W-1:0]    CNT_LAST  = LAST_I[CNT_W-1:0];
    localparam logic [ACC_W-1:0]    ROUND_ADD = HALF_I[ACC_W-1:0];
    localparam logic [DEPTH_LOG2:0] FILL_FULL = DEPTH[DEPTH_LOG2:0];

    logic                    r_eoc_d;
    logic [ACC_W-1:0]        r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic [N_BITS-1:0]       r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_fill;
    logic                    r_overrun;

    logic                    w_sample;
    logic                    w_last;
    logic [ACC_W-1:0]        w_sum;
    logic [ACC_W-1:0]        w_round;
    logic [ACC_W-1:0]        w_shift;
    logic [N_BITS-1:0]       w_avg;
    logic                    w_unused_shift;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_push_req;
    logic                    w_push;
    logic                    w_pop;

    // A sample is the first cycle eoc is seen high. Because r_eoc_d resets
    // to 0, an eoc that is already high when reset releases counts once.
    assign w_sample = en & eoc & ~r_eoc_d;
    assign w_last   = (r_cnt == CNT_LAST);

    // With LOG2_AVG = 0 the rounding term is zero and the shift is a
    // no-op, so the same datapath gives a plain pass-through.
    assign w_sum          = r_acc + ACC_W'(sar);
    assign w_round        = w_sum + ROUND_ADD;
    assign w_shift        = w_round >> LOG2_AVG;
    assign w_avg          = w_shift[N_BITS-1:0];
    assign w_unused_shift = ^w_shift;

    // clr overrides any push or pop. A push into a full FIFO only proceeds
    // when the head is popped in the same cycle, which frees its slot.
    assign w_empty    = (r_fill == '0);
    assign w_full     = (r_fill == FILL_FULL);
    assign w_pop      = ~w_empty & dout_ready & ~clr;
    assign w_push_req = w_sample & w_last & ~clr;
    assign w_push     = w_push_req & (~w_full | w_pop);

    assign dout       = w_empty ? '0 : r_mem[r_rd_ptr];
    assign dout_valid = ~w_empty;
    assign fill       = r_fill;
    assign overrun    = r_overrun;

    // Edge-detect register; keeps tracking eoc even during clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_eoc_d <= 1'b0;
        end else begin
            r_eoc_d <= eoc;
        end
    end

    // Accumulator and sample counter. The final sample of a window is
    // folded in via w_sum rather than stored, then both restart at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_sample) begin
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // FIFO storage needs no reset: the head is only shown when fill > 0.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_avg;
        end
    end

    // FIFO pointers, exact occupancy count and the sticky overrun flag.
    // Pointers are DEPTH_LOG2 bits wide so they wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_fill    <= '0;
            r_overrun <= 1'b0;
        end else if (clr) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_fill    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
            if (w_push_req && !w_push) begin
                r_overrun <= 1'b1;
            end
        end
    end

endmodule
